// File: rtl/nibble_packer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nibble_pkg
// Shared definitions for the nibble packer slice: the nibble width, the
// controller state encoding and a helper that sizes the nibble counter.
// Optional feature macro used elsewhere in this slice: NIBBLE_PACKER_PARITY_EN.
// -----------------------------------------------------------------------------
package nibble_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Counter must represent 0..N inclusive, where N = word_w / NIBBLE_W.
    function automatic int count_w(input int word_w);
        return $clog2(word_w / NIBBLE_W) + 1;
    endfunction

endpackage

// File: rtl/nibble_packer_ctrl_if.sv
// -----------------------------------------------------------------------------
// nibble_packer_ctrl_if
// Bundles the nibble input handshake, the flush request and the word output
// handshake of the packer.
//   master : producer/consumer side (drives in_valid, in_nibble, flush,
//            out_ready)
//   slave  : packer side (drives in_ready, out_valid, out_word, out_count and,
//            with NIBBLE_PACKER_PARITY_EN defined, out_parity)
// -----------------------------------------------------------------------------
interface nibble_packer_ctrl_if #(
    parameter int WORD_W = 16
) ();
    import nibble_pkg::*;

    localparam int CNT_W = count_w(WORD_W);

    logic                in_valid;
    logic                in_ready;
    logic [NIBBLE_W-1:0] in_nibble;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [WORD_W-1:0]   out_word;
    logic [CNT_W-1:0]    out_count;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic                out_parity;

    modport master (
        output in_valid, in_nibble, flush, out_ready,
        input  in_ready, out_valid, out_word, out_count, out_parity
    );
    modport slave (
        input  in_valid, in_nibble, flush, out_ready,
        output in_ready, out_valid, out_word, out_count, out_parity
    );
`else
    modport master (
        output in_valid, in_nibble, flush, out_ready,
        input  in_ready, out_valid, out_word, out_count
    );
    modport slave (
        input  in_valid, in_nibble, flush, out_ready,
        output in_ready, out_valid, out_word, out_count
    );
`endif

endinterface

// File: rtl/nibble_packer_ctrl_pad_concat.sv
// -----------------------------------------------------------------------------
// pad_concat
// Combinational left-padding of a partially filled accumulator.
//   acc  : accumulator, real nibbles right-aligned
//   k    : number of real nibbles (1..N); k == N passes acc through unpadded
//   word : acc with every nibble at or above position k replaced by PAD_BIT
// -----------------------------------------------------------------------------
module pad_concat
    import nibble_pkg::*;
#(
    parameter int   WORD_W  = 16,
    parameter logic PAD_BIT = 1'b1,
    localparam int  N       = WORD_W / NIBBLE_W,
    localparam int  CNT_W   = count_w(WORD_W)
) (
    input  logic [WORD_W-1:0] acc,
    input  logic [CNT_W-1:0]  k,
    output logic [WORD_W-1:0] word
);

    always_comb begin
        // NOTE: assign a default before any conditional update so that no
        // path leaves the output unassigned and infers a latch.
        word = {WORD_W{PAD_BIT}};
        for (int i = 0; i < N; i++) begin
            if (CNT_W'(i) < k) begin
                word[i*NIBBLE_W +: NIBBLE_W] = acc[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

endmodule

// File: rtl/nibble_packer_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_packer_ctrl
// Packs 4-bit nibbles into a WORD_W-bit word. The word is emitted when full,
// or early on flush with the unfilled upper nibbles set to PAD_BIT. The result
// is held on the output until the consumer takes it.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_packer_ctrl_if (nibble input handshake,
//           flush request, word output handshake)
// Optional macro NIBBLE_PACKER_PARITY_EN adds bus.out_parity, the XOR
// reduction of out_word (pad bits included), registered alongside out_word.
// -----------------------------------------------------------------------------
module nibble_packer_ctrl
    import nibble_pkg::*;
#(
    parameter int   WORD_W  = 16,
    parameter logic PAD_BIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_packer_ctrl_if.slave bus
);

    localparam int             N     = WORD_W / NIBBLE_W;
    localparam int             CNT_W = count_w(WORD_W);
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    state_t              state, state_next;
    logic [WORD_W-1:0]   acc, acc_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [WORD_W-1:0]   word_q, padded;
    logic [CNT_W-1:0]    count_q;
    logic                accept, full, flush_go, load, handoff;

    // Accept/flush are only honoured in FILL; a flush in HOLD is dropped.
    assign accept   = bus.in_valid && (state == FILL);
    assign acc_next = accept ? {acc[WORD_W-NIBBLE_W-1:0], bus.in_nibble} : acc;
    assign cnt_next = accept ? cnt + CNT_W'(1) : cnt;
    assign full     = accept && (cnt_next == N_CNT);
    // The same-cycle nibble is counted first, so an empty packer with a
    // simultaneous accept still flushes a one-nibble word.
    assign flush_go = (state == FILL) && bus.flush && (cnt_next != '0) && !full;
    assign load     = full || flush_go;
    assign handoff  = (state == HOLD) && bus.out_ready;

    // k == N on a full word, so the padder passes acc through unchanged.
    pad_concat #(
        .WORD_W  (WORD_W),
        .PAD_BIT (PAD_BIT)
    ) u_pad (
        .acc  (acc_next),
        .k    (cnt_next),
        .word (padded)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (load)    state_next = HOLD;
            HOLD:    if (handoff) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Output logic.
    always_comb begin
        bus.in_ready  = (state == FILL);
        bus.out_valid = (state == HOLD);
        bus.out_word  = word_q;
        bus.out_count = count_q;
    end

    // Accumulator, counter and held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            word_q  <= '0;
            count_q <= '0;
        end else if (state == FILL) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (load) begin
                word_q  <= padded;
                count_q <= cnt_next;
            end
        end else if (handoff) begin
            acc <= '0;
            cnt <= '0;
        end
    end

`ifdef NIBBLE_PACKER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (state == FILL && load) begin
            parity_q <= ^padded;
        end
    end

    assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_nibble_packer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_packer_ctrl
// Directed bench for nibble_packer_ctrl. Three instances: 16-bit with pad 1
// (main), 16-bit with pad 0, and 8-bit with pad 1.
// -----------------------------------------------------------------------------
module tb_nibble_packer_ctrl;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    nibble_packer_ctrl_if #(.WORD_W(16)) if16  ();
    nibble_packer_ctrl_if #(.WORD_W(16)) if16z ();
    nibble_packer_ctrl_if #(.WORD_W(8))  if8   ();

    nibble_packer_ctrl #(.WORD_W(16), .PAD_BIT(1'b1)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(if16));
    nibble_packer_ctrl #(.WORD_W(16), .PAD_BIT(1'b0)) dut16z (
        .clk(clk), .rst_n(rst_n), .bus(if16z));
    nibble_packer_ctrl #(.WORD_W(8), .PAD_BIT(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [3:0]  nib;
        logic        flush;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [15:0] exp_word;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic ir, input logic ov,
                                       input logic [2:0] c,
                                       input logic [15:0] w);
        return {11'b0, ir, ov, c, w};
    endfunction

    function automatic logic [31:0] act16();
        return pk(if16.in_ready, if16.out_valid, if16.out_count, if16.out_word);
    endfunction

    // Advance one cycle and sample #1 after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input logic v, input logic [3:0] n,
                           input logic f, input logic r);
        if16.in_valid  = v;
        if16.in_nibble = n;
        if16.flush     = f;
        if16.out_ready = r;
    endtask

    initial begin
        logic [31:0] a, e;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive16(1'b0, 4'h0, 1'b0, 1'b1);
        if16z.in_valid = 1'b0; if16z.in_nibble = 4'h0;
        if16z.flush = 1'b0;    if16z.out_ready = 1'b1;
        if8.in_valid = 1'b0;   if8.in_nibble = 4'h0;
        if8.flush = 1'b0;      if8.out_ready = 1'b1;

        //      valid nib  flush ordy  ir   ov   word      cnt
        vecs.push_back('{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5CA3, 3'd4});
        vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFF5, 3'd1});
        vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFF7, 3'd1});
        vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 3'd4});
        vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 4'hE, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFF9E, 3'd2});
        vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});

        #12;
        check("reset16", act16(), pk(1'b1, 1'b0, 3'd0, 16'h0000));
        check("reset8", pk(if8.in_ready, if8.out_valid, {1'b0, if8.out_count},
                           {8'h00, if8.out_word}),
              pk(1'b1, 1'b0, 3'd0, 16'h0000));
        rst_n = 1'b1;
        #2;

        // Table: word/count are only compared while out_valid is expected.
        for (int i = 0; i < vecs.size(); i++) begin
            drive16(vecs[i].valid, vecs[i].nib, vecs[i].flush, vecs[i].ordy);
            tick();
            if (vecs[i].exp_ov) begin
                a = act16();
                e = pk(vecs[i].exp_ir, 1'b1, vecs[i].exp_cnt, vecs[i].exp_word);
            end else begin
                a = pk(if16.in_ready, if16.out_valid, 3'd0, 16'h0000);
                e = pk(vecs[i].exp_ir, 1'b0, 3'd0, 16'h0000);
            end
            check($sformatf("vec%0d", i), a, e);
        end

        // Back-pressure: result held, input stalled, flush in HOLD dropped.
        for (int i = 1; i <= 4; i++) begin
            drive16(1'b1, 4'(i), 1'b0, 1'b0);
            tick();
        end
        check("stall_full", act16(), pk(1'b0, 1'b1, 3'd4, 16'h1234));
        for (int j = 0; j < 5; j++) begin
            drive16(1'b1, 4'hF, (j == 2), 1'b0);
            tick();
            check($sformatf("stall_hold%0d", j), act16(),
                  pk(1'b0, 1'b1, 3'd4, 16'h1234));
        end
        // Handoff with in_valid still high: no pass-through of 0xF.
        drive16(1'b1, 4'hF, 1'b0, 1'b1);
        tick();
        check("stall_handoff", pk(if16.in_ready, if16.out_valid, 3'd0, 16'h0),
              pk(1'b1, 1'b0, 3'd0, 16'h0));
        drive16(1'b1, 4'hA, 1'b0, 1'b1); tick();
        check("after_hold_a", pk(if16.in_ready, if16.out_valid, 3'd0, 16'h0),
              pk(1'b1, 1'b0, 3'd0, 16'h0));
        drive16(1'b1, 4'hB, 1'b0, 1'b1); tick();
        drive16(1'b1, 4'hC, 1'b0, 1'b1); tick();
        check("after_hold_c", pk(if16.in_ready, if16.out_valid, 3'd0, 16'h0),
              pk(1'b1, 1'b0, 3'd0, 16'h0));
        drive16(1'b1, 4'hD, 1'b0, 1'b1); tick();
        check("after_hold_word", act16(), pk(1'b0, 1'b1, 3'd4, 16'hABCD));
        drive16(1'b0, 4'h0, 1'b0, 1'b1); tick();

        // Reset mid-operation discards the partial word asynchronously.
        drive16(1'b1, 4'h1, 1'b0, 1'b1); tick();
        drive16(1'b1, 4'h2, 1'b0, 1'b1); tick();
        drive16(1'b0, 4'h0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", act16(), pk(1'b1, 1'b0, 3'd0, 16'h0000));
        #3;
        rst_n = 1'b1;
        drive16(1'b1, 4'hA, 1'b0, 1'b1); tick();
        drive16(1'b1, 4'hB, 1'b0, 1'b1); tick();
        drive16(1'b1, 4'hC, 1'b0, 1'b1); tick();
        drive16(1'b1, 4'hD, 1'b0, 1'b1); tick();
        check("post_reset_word", act16(), pk(1'b0, 1'b1, 3'd4, 16'hABCD));
        drive16(1'b0, 4'h0, 1'b0, 1'b1); tick();

        // Pad bit 0.
        if16z.in_valid = 1'b1; if16z.in_nibble = 4'h5; tick();
        if16z.in_valid = 1'b0; if16z.flush = 1'b1; tick();
        if16z.flush = 1'b0;
        check("pad0_flush", pk(if16z.in_ready, if16z.out_valid,
                               if16z.out_count, if16z.out_word),
              pk(1'b0, 1'b1, 3'd1, 16'h0005));
        tick();
        check("pad0_handoff", pk(if16z.in_ready, if16z.out_valid, 3'd0, 16'h0),
              pk(1'b1, 1'b0, 3'd0, 16'h0));

        // 8-bit word: accept + flush together, then a full word.
        if8.in_valid = 1'b1; if8.in_nibble = 4'h5; if8.flush = 1'b1; tick();
        if8.in_valid = 1'b0; if8.flush = 1'b0;
        check("w8_flush", pk(if8.in_ready, if8.out_valid, {1'b0, if8.out_count},
                             {8'h00, if8.out_word}),
              pk(1'b0, 1'b1, 3'd1, 16'h00F5));
        tick();
        if8.in_valid = 1'b1; if8.in_nibble = 4'h5; tick();
        if8.in_nibble = 4'hC; tick();
        if8.in_valid = 1'b0;
        check("w8_full", pk(if8.in_ready, if8.out_valid, {1'b0, if8.out_count},
                            {8'h00, if8.out_word}),
              pk(1'b0, 1'b1, 3'd2, 16'h005C));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
